// File: rtl/args_encode_if.sv
// rtl/args_encode_if.sv - request/grant/channel-number bundle for args_encode
interface args_encode_if #(
    parameter int N = 2
);
    localparam int W = 1 << N;

    logic [W-1:0] req;
    logic         rdy;
    logic         vld;
    logic [N-1:0] c;
    logic [W-1:0] gnt;
    logic [W-1:0] ack;

    // Encoder side: consumes requests and ready, drives the channel number.
    modport master (
        input  req,
        input  rdy,
        output vld,
        output c,
        output gnt,
        output ack
    );

    // Requester/consumer side.
    modport slave (
        output req,
        output rdy,
        input  vld,
        input  c,
        input  gnt,
        input  ack
    );
endinterface

// File: rtl/args_encode.sv
// rtl/args_encode.sv - round-robin arbitrating encoder with valid/ready channel-number output
module args_encode #(
    parameter int N = 2
) (
    input  logic       clk,
    input  logic       rst,
    args_encode_if.master bus
);
    localparam int W = 1 << N;

    typedef enum logic {
        IDLE,
        OUT
    } state_t;

    state_t       state_q, state_n;
    logic [N-1:0] ptr_q, ptr_n;
    logic [N-1:0] c_q, c_n;
    logic [W-1:0] gnt_q, gnt_n;
    logic [W-1:0] ack_q, ack_n;
    logic         vld_q, vld_n;
    logic [N-1:0] pick;
    logic [N-1:0] idx;

    // Round-robin search: scanning from the far end toward ptr leaves the
    // closest requester at or after ptr as the winner.
    always_comb begin
        pick = ptr_q;
        idx  = '0;
        for (int k = W - 1; k >= 0; k--) begin
            idx = ptr_q + N'(k);
            if (bus.req[idx]) begin
                pick = idx;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        c_n     = c_q;
        gnt_n   = gnt_q;
        vld_n   = vld_q;
        ack_n   = '0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    c_n        = pick;
                    gnt_n      = '0;
                    gnt_n[pick] = 1'b1;
                    vld_n      = 1'b1;
                    state_n    = OUT;
                end else begin
                    vld_n = 1'b0;
                    gnt_n = '0;
                end
            end
            OUT: begin
                // Grant is committed: req is ignored until the handshake.
                if (bus.rdy) begin
                    vld_n   = 1'b0;
                    gnt_n   = '0;
                    ack_n   = gnt_q;
                    ptr_n   = c_q + 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
                gnt_n   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any grant in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            c_q     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            c_q     <= c_n;
            gnt_q   <= gnt_n;
            ack_q   <= ack_n;
            vld_q   <= vld_n;
        end
    end

    assign bus.vld = vld_q;
    assign bus.c   = c_q;
    assign bus.gnt = gnt_q;
    assign bus.ack = ack_q;
endmodule
